// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16 ALU controller: ALU opcodes, PSR bit indices,
// instruction fields and FSM states. CR16_CMP_EN enables the CMP/CMPI opext.
package cr16_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_ADDC = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_XOR  = 4'd8;
  localparam logic [3:0] ALU_LSH  = 4'd10;
  localparam logic [3:0] ALU_RSH  = 4'd11;

  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_L = 1;
  localparam int unsigned PSR_F = 2;
  localparam int unsigned PSR_Z = 3;
  localparam int unsigned PSR_N = 4;

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b1000;

  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_ADDC = 4'b0111;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_ILL
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] alu_op;
    logic       sign_ext;
    logic       is_cmp;
  } ext_map_t;

  // Register and immediate forms share the opext code space, so one table serves both.
  function automatic ext_map_t map_ext(input logic [3:0] ext);
    ext_map_t m;
    m       = '0;
    m.legal = 1'b1;
    case (ext)
      EXT_AND:  m.alu_op = ALU_AND;
      EXT_OR:   m.alu_op = ALU_OR;
      EXT_XOR:  m.alu_op = ALU_XOR;
      EXT_ADDU: m.alu_op = ALU_ADDU;
      EXT_ADD: begin
        m.alu_op   = ALU_ADD;
        m.sign_ext = 1'b1;
      end
      EXT_ADDC: begin
        m.alu_op   = ALU_ADDC;
        m.sign_ext = 1'b1;
      end
      EXT_SUB: begin
        m.alu_op   = ALU_SUB;
        m.sign_ext = 1'b1;
      end
      EXT_CMP: begin
`ifdef CR16_CMP_EN
        m.alu_op   = ALU_SUB;
        m.sign_ext = 1'b1;
        m.is_cmp   = 1'b1;
`else
        m.legal    = 1'b0;
`endif
      end
      default: m.legal = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cr16_instr_decode.sv
// Combinational CR16 instruction decoder: ALU opcode plus operand-mux and
// write-back controls. CMP/CMPI legality follows CR16_CMP_EN.
module cr16_instr_decode
  import cr16_pkg::*;
(
  input  logic [15:0] i_instr,
  output logic [3:0]  o_alu_op,
  output logic        o_use_imm,
  output logic        o_sign_ext,
  output logic        o_swap_ab,
  output logic        o_wb_en,
  output logic        o_illegal
);

  logic [3:0] w_op;
  ext_map_t   w_map;

  assign w_op  = i_instr[15:12];
  assign w_map = map_ext((w_op == OP_REG) ? i_instr[7:4] : w_op);

  always_comb begin
    o_alu_op   = '0;
    o_use_imm  = 1'b0;
    o_sign_ext = 1'b0;
    o_swap_ab  = 1'b0;
    o_wb_en    = 1'b0;
    o_illegal  = 1'b1;
    if (w_op == OP_SHIFT) begin
      if (i_instr[7:5] == 3'b000) begin
        o_alu_op  = i_instr[4] ? ALU_RSH : ALU_LSH;
        o_use_imm = 1'b1;
        o_swap_ab = 1'b1;
        o_wb_en   = 1'b1;
        o_illegal = 1'b0;
      end
    end else if (w_map.legal) begin
      o_alu_op   = w_map.alu_op;
      o_use_imm  = (w_op != OP_REG);
      o_sign_ext = w_map.sign_ext;
      o_wb_en    = !w_map.is_cmp;
      o_illegal  = 1'b0;
    end
  end

endmodule

// File: rtl/cr16_alu_ctrl.sv
// CR16 ALU initiator: accepts an instruction, reads operands, drives the ALU
// for one cycle, writes back and updates the PSR. Optional macro: CR16_CMP_EN.
module cr16_alu_ctrl
  import cr16_pkg::*;
#(
  parameter int unsigned P_WIDTH = 16
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic               I_INSTR_VALID,
  output logic               O_INSTR_READY,
  input  logic [15:0]        I_INSTR,
  output logic [3:0]         O_RS_ADDR,
  output logic [3:0]         O_RD_ADDR,
  input  logic [P_WIDTH-1:0] I_RS_DATA,
  input  logic [P_WIDTH-1:0] I_RD_DATA,
  output logic               O_ALU_ENABLE,
  output logic [3:0]         O_ALU_OPCODE,
  output logic [P_WIDTH-1:0] O_ALU_A,
  output logic [P_WIDTH-1:0] O_ALU_B,
  input  logic [P_WIDTH-1:0] I_ALU_C,
  input  logic [4:0]         I_ALU_STATUS,
  output logic               O_WB_EN,
  output logic [3:0]         O_WB_ADDR,
  output logic [P_WIDTH-1:0] O_WB_DATA,
  output logic [4:0]         O_PSR,
  output logic               O_ILLEGAL
);

  state_t             r_state;
  logic               r_ready;
  logic [15:0]        r_instr;
  logic [3:0]         r_rs_addr;
  logic [3:0]         r_rd_addr;
  logic               r_alu_en;
  logic [3:0]         r_alu_op;
  logic [P_WIDTH-1:0] r_alu_a;
  logic [P_WIDTH-1:0] r_alu_b;
  logic               r_wb_req;
  logic               r_wb_en;
  logic [3:0]         r_wb_addr;
  logic [4:0]         r_psr;
  logic               r_illegal;

  logic [3:0]         w_alu_op;
  logic               w_use_imm;
  logic               w_sign_ext;
  logic               w_swap_ab;
  logic               w_wb_en;
  logic               w_illegal;
  logic [7:0]         w_imm8;
  logic [P_WIDTH-1:0] w_imm_ext;
  logic [P_WIDTH-1:0] w_shamt;
  logic [P_WIDTH-1:0] w_a;
  logic [P_WIDTH-1:0] w_b;
  logic [4:0]         w_psr_next;

  cr16_instr_decode u_decode (
    .i_instr    (r_instr),
    .o_alu_op   (w_alu_op),
    .o_use_imm  (w_use_imm),
    .o_sign_ext (w_sign_ext),
    .o_swap_ab  (w_swap_ab),
    .o_wb_en    (w_wb_en),
    .o_illegal  (w_illegal)
  );

  assign w_imm8    = r_instr[7:0];
  assign w_imm_ext = w_sign_ext ? {{(P_WIDTH-8){w_imm8[7]}}, w_imm8}
                                : {{(P_WIDTH-8){1'b0}}, w_imm8};
  assign w_shamt   = {{(P_WIDTH-4){1'b0}}, r_instr[3:0]};

  // Shifts operate on Rdest, so the operand roles flip relative to ALU ops.
  always_comb begin
    w_a = '0;
    w_b = '0;
    if (w_swap_ab) begin
      w_a = I_RD_DATA;
      w_b = w_shamt;
    end else begin
      w_a = w_use_imm ? w_imm_ext : I_RS_DATA;
      w_b = I_RD_DATA;
    end
  end

  assign w_psr_next[PSR_C] = I_ALU_STATUS[PSR_C];
  assign w_psr_next[PSR_L] = I_ALU_STATUS[PSR_L];
  assign w_psr_next[PSR_F] = I_ALU_STATUS[PSR_F];
  assign w_psr_next[PSR_Z] = I_ALU_STATUS[PSR_Z];
  assign w_psr_next[PSR_N] = I_ALU_STATUS[PSR_N];

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b1;
      r_instr   <= '0;
      r_rs_addr <= '0;
      r_rd_addr <= '0;
      r_alu_en  <= 1'b0;
      r_alu_op  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_wb_req  <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_psr     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_alu_en  <= 1'b0;
      r_wb_en   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (I_INSTR_VALID && r_ready) begin
            r_instr   <= I_INSTR;
            r_rs_addr <= I_INSTR[3:0];
            r_rd_addr <= I_INSTR[11:8];
            r_ready   <= 1'b0;
            r_state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_rs_addr <= '0;
          r_rd_addr <= '0;
          if (w_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= ST_ILL;
          end else begin
            r_alu_en <= 1'b1;
            r_alu_op <= w_alu_op;
            r_alu_a  <= w_a;
            r_alu_b  <= w_b;
            r_wb_req <= w_wb_en;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_alu_op  <= '0;
          r_alu_a   <= '0;
          r_alu_b   <= '0;
          r_wb_en   <= r_wb_req;
          r_wb_addr <= r_wb_req ? r_instr[11:8] : '0;
          r_state   <= ST_WB;
        end
        ST_WB: begin
          r_psr     <= w_psr_next;
          r_wb_addr <= '0;
          r_wb_req  <= 1'b0;
          r_ready   <= 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_ILL: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_INSTR_READY = r_ready;
  assign O_RS_ADDR     = r_rs_addr;
  assign O_RD_ADDR     = r_rd_addr;
  assign O_ALU_ENABLE  = r_alu_en;
  assign O_ALU_OPCODE  = r_alu_op;
  assign O_ALU_A       = r_alu_a;
  assign O_ALU_B       = r_alu_b;
  assign O_WB_EN       = r_wb_en;
  assign O_WB_ADDR     = r_wb_addr;
  // The ALU result only arrives in the WB cycle, so write data is gated, not registered.
  assign O_WB_DATA     = r_wb_en ? I_ALU_C : '0;
  assign O_PSR         = r_psr;
  assign O_ILLEGAL     = r_illegal;

endmodule
